// File: rtl/rc6_block_reg.sv
// RC6 block state register: holds the 4-word block from external load through
// R round-result writes, then presents the finished block until consumed.
module rc6_block_reg #(
    parameter int W         = 32,
    parameter int R         = 20,
    parameter int BYTE_SWAP = 0
) (
    input  logic           inClk,
    input  logic           inReset,
    input  logic           inExtValid,
    output logic           outExtReady,
    input  logic [4*W-1:0] inExtData,
    input  logic           inKeyReady,
    input  logic           inIntWr,
    input  logic [4*W-1:0] inIntData,
    output logic [4*W-1:0] outData,
    output logic [7:0]     outRound,
    output logic           outBusy,
    output logic           outValid,
    input  logic           inOutReady
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(R - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [4*W-1:0] r_data;
    logic [7:0]     r_round;
    logic [4*W-1:0] w_swapped;
    logic [4*W-1:0] w_load_data;
    logic           w_load;
    logic           w_wr;
    logic           w_clr_round;

    // Byte reversal within each W-bit word; word order is untouched.
    always_comb begin
        w_swapped = inExtData;
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < W / 8; b++) begin
                w_swapped[w*W + b*8 +: 8] = inExtData[w*W + (W/8 - 1 - b)*8 +: 8];
            end
        end
    end

    assign w_load_data = (BYTE_SWAP != 0) ? w_swapped : inExtData;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_wr        = 1'b0;
        w_clr_round = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (inExtValid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (inKeyReady) begin
                    w_clr_round = 1'b1;
                    w_state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (inIntWr) begin
                    w_wr = 1'b1;
                    if (r_round == LP_LAST) w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Release only; a block offered in this same cycle waits for IDLE.
                if (inOutReady) begin
                    w_clr_round = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge inClk) begin
        if (inReset) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_round <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load)
                r_data <= w_load_data;
            else if (w_wr)
                r_data <= inIntData;
            if (w_clr_round)
                r_round <= '0;
            else if (w_wr)
                r_round <= r_round + 8'd1;
        end
    end

    assign outData     = r_data;
    assign outRound    = r_round;
    assign outExtReady = (r_state == ST_IDLE);
    assign outBusy     = (r_state == ST_LOAD) || (r_state == ST_ROUND);
    assign outValid    = (r_state == ST_DONE);

endmodule

// File: tb/tb_rc6_block_reg.sv
// Bench for rc6_block_reg: two instances (plain R=20, byte-swapped R=3) on shared
// stimulus, each compared every cycle against a phase-level model.
module tb_rc6_block_reg;

    logic         inClk = 1'b0;
    logic         inReset, inExtValid, inKeyReady, inIntWr, inOutReady;
    logic [127:0] inExtData, inIntData;
    logic         rdy0, busy0, vld0, rdy1, busy1, vld1;
    logic [127:0] dat0, dat1;
    logic [7:0]   rnd0, rnd1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    always #5 inClk = ~inClk;

    rc6_block_reg #(.W(32), .R(20), .BYTE_SWAP(0)) dut0 (
        .inClk(inClk), .inReset(inReset), .inExtValid(inExtValid), .outExtReady(rdy0),
        .inExtData(inExtData), .inKeyReady(inKeyReady), .inIntWr(inIntWr),
        .inIntData(inIntData), .outData(dat0), .outRound(rnd0), .outBusy(busy0),
        .outValid(vld0), .inOutReady(inOutReady));

    rc6_block_reg #(.W(32), .R(3), .BYTE_SWAP(1)) dut1 (
        .inClk(inClk), .inReset(inReset), .inExtValid(inExtValid), .outExtReady(rdy1),
        .inExtData(inExtData), .inKeyReady(inKeyReady), .inIntWr(inIntWr),
        .inIntData(inIntData), .outData(dat1), .outRound(rnd1), .outBusy(busy1),
        .outValid(vld1), .inOutReady(inOutReady));

    // phase: 0 waiting for a block, 1 waiting for key, 2 taking round writes, 3 holding result
    typedef struct {
        int           ph;
        logic [127:0] data;
        int           cnt;
    } mdl_t;

    mdl_t m0, m1;

    function automatic logic [127:0] swap_words(input logic [127:0] d);
        logic [127:0] o;
        logic [31:0]  w;
        for (int i = 0; i < 4; i++) begin
            w = d[i*32 +: 32];
            o[i*32 +: 32] = {<<8{w}};
        end
        return o;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input int rr, input bit bs);
        mdl_t n = m;
        if (inReset) begin
            n.ph = 0; n.data = '0; n.cnt = 0;
            return n;
        end
        if (m.ph == 0 && inExtValid) begin
            n.data = bs ? swap_words(inExtData) : inExtData;
            n.ph = 1;
        end else if (m.ph == 1 && inKeyReady) begin
            n.ph = 2; n.cnt = 0;
        end else if (m.ph == 2 && inIntWr) begin
            n.data = inIntData;
            n.cnt  = m.cnt + 1;
            if (n.cnt == rr) n.ph = 3;
        end else if (m.ph == 3 && inOutReady) begin
            n.ph = 0; n.cnt = 0;
        end
        return n;
    endfunction

    always @(posedge inClk) begin
        m0 = mstep(m0, 20, 1'b0);
        m1 = mstep(m1, 3, 1'b1);
    end

    function automatic logic [138:0] expect_of(input mdl_t m);
        return {m.data, 8'(m.cnt), m.ph == 0, m.ph == 1 || m.ph == 2, m.ph == 3};
    endfunction

    always @(negedge inClk) begin
        if (chk_en) begin
            checks++;
            if ({dat0, rnd0, rdy0, busy0, vld0} !== expect_of(m0)) begin
                errors++;
                $display("FAIL dut0_cycle t=%0t got=%h want=%h", $time,
                         {dat0, rnd0, rdy0, busy0, vld0}, expect_of(m0));
            end
            checks++;
            if ({dat1, rnd1, rdy1, busy1, vld1} !== expect_of(m1)) begin
                errors++;
                $display("FAIL dut1_cycle t=%0t got=%h want=%h", $time,
                         {dat1, rnd1, rdy1, busy1, vld1}, expect_of(m1));
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge inClk);
        #1;
    endtask

    localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] BLK_S = 128'h0C0D0E0F_08090A0B_04050607_00010203;
    localparam logic [127:0] BLK_E = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

    initial begin
        m0 = '{0, '0, 0};
        m1 = '{0, '0, 0};
        inReset = 1; inExtValid = 0; inKeyReady = 0; inIntWr = 0; inOutReady = 0;
        inExtData = '0; inIntData = '0;
        #1;
        tick(); tick();
        inReset = 0;
        chk_en = 1;

        check("reset_data", dat0, '0);
        check("reset_round", 128'(rnd0), 0);
        check("reset_flags", 128'({rdy0, busy0, vld0}), 128'(3'b100));

        // byte swap on load
        inExtValid = 1; inExtData = BLK_S;
        tick();
        check("swap_data", dat1, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        check("noswap_data", dat0, BLK_S);
        check("load_busy", 128'({rdy0, busy0, vld0}), 128'(3'b010));
        inExtValid = 0; inReset = 1;
        tick();
        inReset = 0;
        check("reset_in_load", 128'({dat0, rdy0, busy0, vld0} == {128'd0, 3'b100}), 1);

        // full block, minimum latency
        inExtValid = 1; inExtData = BLK_A; inKeyReady = 1;
        tick();
        inExtValid = 0;
        tick();
        check("round_entry", 128'({rnd0, busy0}), 128'({8'd0, 1'b1}));
        for (int n = 1; n <= 20; n++) begin
            inIntWr = 1; inIntData = 128'(n);
            tick();
            if (n == 19) check("pre_done_valid", 128'({vld0, rnd0}), 128'({1'b0, 8'd19}));
        end
        inIntWr = 0;
        check("done_valid", 128'(vld0), 1);
        check("done_data", dat0, 128'd20);
        check("done_round", 128'(rnd0), 20);

        // hold in DONE, then simultaneous release and offer
        for (int i = 0; i < 5; i++) begin
            tick();
            check("done_hold", 128'({vld0, dat0 == 128'd20}), 128'(2'b11));
        end
        inOutReady = 1; inExtValid = 1; inExtData = BLK_E;
        tick();
        check("release_no_capture", 128'({rdy0, vld0, dat0 == 128'd20}), 128'(3'b101));
        inOutReady = 0;
        tick();
        check("capture_after_release", dat0, BLK_E);
        check("capture_swap", dat1, swap_words(BLK_E));
        inExtValid = 0;

        // reset in ROUND at round 7 with a write pending
        inReset = 1;
        tick();
        inReset = 0; inExtValid = 1; inExtData = BLK_A; inKeyReady = 1;
        tick();
        inExtValid = 0;
        tick();
        for (int n = 1; n <= 7; n++) begin
            inIntWr = 1; inIntData = 128'(n + 100);
            tick();
        end
        check("round7", 128'(rnd0), 7);
        inReset = 1;
        tick();
        inReset = 0; inIntWr = 0;
        check("reset_mid_round", 128'({dat0, rnd0, rdy0, busy0, vld0}),
              128'({128'd0, 8'd0, 3'b100}));

        // random traffic, including strobes in states where they must be ignored
        for (int i = 0; i < 4000; i++) begin
            inReset    = ($urandom_range(0, 199) == 0);
            inExtValid = ($urandom_range(0, 9) < 3);
            inKeyReady = ($urandom_range(0, 1) == 1);
            inIntWr    = ($urandom_range(0, 9) < 7);
            inOutReady = ($urandom_range(0, 9) < 3);
            inExtData  = {$urandom, $urandom, $urandom, $urandom};
            inIntData  = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
